pdp8_mem_arbiter: RTL and testbench
===================================

Name: pdp8_mem_arbiter

Overview:
- Sits between the IFD fetch port, the execution unit's data ports, and the single-ported synchronous main memory (4096 x 12).
- Arbitrates the three requesters onto the one memory port and returns read data or write completion to the winner.
- Exec writes have highest priority and IFD fetches lowest.
- A starvation guard promotes IFD fetches after repeated losses.

Parameters:
ADDR_WIDTH, 12, address width (`ADDR_WIDTH)
DATA_WIDTH, 12, data word width (`DATA_WIDTH)
STARVE_LIMIT, 4, consecutive IDLE-cycle losses after which IFD gets top priority

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
ifu_rd_req  in  1  IFD fetch request, level, held until ifu_rd_valid
ifu_rd_addr  in  ADDR_WIDTH  fetch address
ifu_rd_data  out  DATA_WIDTH  fetched word, valid with ifu_rd_valid, held afterwards
ifu_rd_valid  out  1  one-cycle pulse, fetch complete
exec_rd_req  in  1  exec read request, level
exec_rd_addr  in  ADDR_WIDTH  exec read address
exec_rd_data  out  DATA_WIDTH  exec read word, held afterwards
exec_rd_valid  out  1  one-cycle pulse, exec read complete
exec_wr_req  in  1  exec write request, level
exec_wr_addr  in  ADDR_WIDTH  exec write address
exec_wr_data  in  DATA_WIDTH  exec write data
exec_wr_done  out  1  one-cycle pulse, write committed
mem_en  out  1  memory enable, registered
mem_we  out  1  memory write enable, registered
mem_addr  out  ADDR_WIDTH  memory address, registered
mem_wdata  out  DATA_WIDTH  memory write data, registered
mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after mem_en&&!mem_we

Behaviour:
Clock and reset:
- Single clock domain.
- Reset is asynchronous, active-low, on reset_n.

Reset values:
- FSM = IDLE.
- All outputs 0.
- Starvation counter 0.

FSM states IDLE, ACCESS, DATA, RESP:
- IDLE: sample requests at each rising edge.
  - Default priority: exec_wr_req > exec_rd_req > ifu_rd_req.
  - If starve_cnt >= STARVE_LIMIT and ifu_rd_req=1, IFD wins outright.
  - On any grant, register mem_addr/mem_we/mem_wdata, set mem_en=1, latch the grant owner, go to ACCESS.
  - No request: stay in IDLE, mem_en=0.
- ACCESS: mem_en high for exactly this cycle.
  - Read grant: next state DATA.
  - Write grant: next state RESP.
  - mem_en drops on exit.
- DATA: mem_rdata is valid. At the closing edge, capture it into the owner's rd_data register, raise the owner's valid, go to RESP.
- RESP: the owner's valid/done is high for this cycle only. Next state is IDLE.

Latency:
- Read request sampled at edge T: mem_en high in cycle T..T+1, valid high in cycle T+2..T+3, i.e. 3 cycles.
- Write: done high 2 cycles after the sampling edge.

Requester handshake:
- Requests are only sampled in IDLE.
- A requester must drop req (or change address) on the edge at which it samples valid/done.
- Req still high in the following IDLE is treated as a new request.
- Request inputs are ignored in ACCESS/DATA/RESP.
- Address/data must be held stable while req is high.

Starvation counter:
- Increments (saturating at STARVE_LIMIT) in each IDLE cycle where ifu_rd_req=1 and IFD loses.
- Clears when IFD is granted.
- Clears when ifu_rd_req=0 in IDLE.

Simultaneous events:
- exec_wr_req and exec_rd_req both high: the write goes first, and the read is served on a later IDLE.
- Same-address exec write then IFD fetch: the fetch returns the new data (strict serialization).

Hold behaviour:
- rd_data registers keep their last value until the next completion for that owner.
- mem_addr/mem_wdata hold their last value when mem_en=0.

Reset mid-transaction:
- The transaction is dropped and no valid/done is issued.
- mem_en/mem_we go low immediately (asynchronously).
- The FSM restarts in IDLE.

Optional Feature:
Macro PDP8_MEM_ARB_STATS_EN.
- Defined: adds output ports ifu_grant_cnt[15:0], exec_grant_cnt[15:0], conflict_cnt[15:0].
  - ifu_grant_cnt increments on IFD grants; exec_grant_cnt on exec grants (read or write).
  - conflict_cnt increments per IDLE grant cycle with two or more requests high.
  - All three saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. Memory preloaded with o200=12'o1234. ifu_rd_req=1, addr=o200 sampled at edge T -> ifu_rd_valid=1 in cycle T+2..T+3, ifu_rd_data=12'o1234, mem_en high exactly one cycle.
2. exec_wr_req (addr o300, data 12'o7777) and ifu_rd_req (addr o300) both high in IDLE -> write granted first, exec_wr_done pulses; the next IDLE grants IFD, which returns 12'o7777.
3. Starvation: exec_rd_req held high with a new address on every completion, and ifu_rd_req held high -> after 4 lost IDLE cycles, the 5th IDLE grants IFD despite exec_rd_req=1.
4. reset_n pulled low during DATA of an exec read -> no exec_rd_valid; all outputs 0 immediately. After release, a fetch of o200 completes in 3 cycles.
5. Requester holds ifu_rd_req high one extra cycle after valid -> a second fetch is issued and a second ifu_rd_valid pulse arrives 3 cycles later.
6. With PDP8_MEM_ARB_STATS_EN defined, 3 IFD fetches + 2 exec writes, one of them contended -> ifu_grant_cnt=3, exec_grant_cnt=2, conflict_cnt=1.

Source files
------------

// File: rtl/pdp8_mem_arbiter.sv
// -----------------------------------------------------------------------------
// pdp8_mem_arbiter
//
// Arbitrates the IFD fetch port and the execution unit's read and write ports
// onto one single-ported synchronous 4096 x 12 main memory. Only one access is
// in flight at a time: requests are sampled in IDLE, the winner owns the memory
// port through ACCESS (and DATA for reads), and gets a one-cycle valid/done in
// RESP.
//
// Priority: exec write > exec read > IFD fetch. An IFD fetch that has lost
// STARVE_LIMIT consecutive IDLE arbitrations wins outright on the next one.
//
// Ports:
//   clk, reset_n                     clock (rising edge), async active-low reset
//   ifu_rd_req/addr -> data/valid    IFD fetch port
//   exec_rd_req/addr -> data/valid   exec read port
//   exec_wr_req/addr/data -> done    exec write port
//   mem_en/we/addr/wdata, mem_rdata  registered memory port; read data is valid
//                                    the cycle after mem_en && !mem_we
//
// Optional build macro PDP8_MEM_ARB_STATS_EN adds saturating 16-bit counters
// ifu_grant_cnt, exec_grant_cnt and conflict_cnt as extra outputs.
// -----------------------------------------------------------------------------
module pdp8_mem_arbiter #(
   parameter int ADDR_WIDTH   = 12,
   parameter int DATA_WIDTH   = 12,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  ifu_rd_req,
   input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
   output logic [DATA_WIDTH-1:0] ifu_rd_data,
   output logic                  ifu_rd_valid,
   input  logic                  exec_rd_req,
   input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
   output logic [DATA_WIDTH-1:0] exec_rd_data,
   output logic                  exec_rd_valid,
   input  logic                  exec_wr_req,
   input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
   input  logic [DATA_WIDTH-1:0] exec_wr_data,
   output logic                  exec_wr_done,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef PDP8_MEM_ARB_STATS_EN
   ,
   output logic [15:0]           ifu_grant_cnt,
   output logic [15:0]           exec_grant_cnt,
   output logic [15:0]           conflict_cnt
`endif
);

   // Starvation counter wide enough to hold STARVE_LIMIT itself (it saturates there)
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DATA   = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE    = 2'd0,
      OWN_IFU     = 2'd1,
      OWN_EXEC_RD = 2'd2,
      OWN_EXEC_WR = 2'd3
   } owner_t;

   state_t                state_r;
   state_t                state_s;
   owner_t                owner_r;
   owner_t                grant_s;
   logic [SW-1:0]         starve_cnt_r;
   logic [SW-1:0]         starve_cnt_s;
   logic [ADDR_WIDTH-1:0] grant_addr_s;
   logic                  ifu_starving_s;

   // Next state, IDLE arbitration and starvation-counter update
   always_comb begin
      state_s        = state_r;
      grant_s        = OWN_NONE;
      grant_addr_s   = ifu_rd_addr;
      starve_cnt_s   = starve_cnt_r;
      ifu_starving_s = ifu_rd_req && (starve_cnt_r >= STARVE_MAX);
      case (state_r)
         ST_IDLE: begin
            if (ifu_starving_s) begin
               grant_s      = OWN_IFU;
               grant_addr_s = ifu_rd_addr;
            end else if (exec_wr_req) begin
               grant_s      = OWN_EXEC_WR;
               grant_addr_s = exec_wr_addr;
            end else if (exec_rd_req) begin
               grant_s      = OWN_EXEC_RD;
               grant_addr_s = exec_rd_addr;
            end else if (ifu_rd_req) begin
               grant_s      = OWN_IFU;
               grant_addr_s = ifu_rd_addr;
            end else begin
               grant_s      = OWN_NONE;
            end

            if (grant_s != OWN_NONE) begin
               state_s = ST_ACCESS;
            end else begin
               state_s = ST_IDLE;
            end

            // Counts only consecutive losses of a pending fetch
            if (!ifu_rd_req || (grant_s == OWN_IFU)) begin
               starve_cnt_s = {SW{1'b0}};
            end else if (starve_cnt_r < STARVE_MAX) begin
               starve_cnt_s = starve_cnt_r + SW'(1'b1);
            end else begin
               starve_cnt_s = starve_cnt_r;
            end
         end
         ST_ACCESS: begin
            if (owner_r == OWN_EXEC_WR) begin
               state_s = ST_RESP;
            end else begin
               state_s = ST_DATA;
            end
         end
         ST_DATA: begin
            state_s = ST_RESP;
         end
         ST_RESP: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, grant owner and starvation counter registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= ST_IDLE;
         owner_r      <= OWN_NONE;
         starve_cnt_r <= {SW{1'b0}};
      end else begin
         state_r      <= state_s;
         starve_cnt_r <= starve_cnt_s;
         if ((state_r == ST_IDLE) && (grant_s != OWN_NONE)) begin
            owner_r <= grant_s;
         end else begin
            owner_r <= owner_r;
         end
      end
   end

   // Registered memory port, read-data capture and completion pulses
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_en        <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= {ADDR_WIDTH{1'b0}};
         mem_wdata     <= {DATA_WIDTH{1'b0}};
         ifu_rd_data   <= {DATA_WIDTH{1'b0}};
         ifu_rd_valid  <= 1'b0;
         exec_rd_data  <= {DATA_WIDTH{1'b0}};
         exec_rd_valid <= 1'b0;
         exec_wr_done  <= 1'b0;
      end else begin
         // Completion strobes are single-cycle unless set below
         ifu_rd_valid  <= 1'b0;
         exec_rd_valid <= 1'b0;
         exec_wr_done  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (grant_s != OWN_NONE) begin
                  mem_en   <= 1'b1;
                  mem_we   <= (grant_s == OWN_EXEC_WR);
                  mem_addr <= grant_addr_s;
                  if (grant_s == OWN_EXEC_WR) begin
                     mem_wdata <= exec_wr_data;
                  end
               end
            end
            ST_ACCESS: begin
               // The memory commits the write on this edge, so done can follow now
               mem_en <= 1'b0;
               mem_we <= 1'b0;
               if (owner_r == OWN_EXEC_WR) begin
                  exec_wr_done <= 1'b1;
               end
            end
            ST_DATA: begin
               case (owner_r)
                  OWN_IFU: begin
                     ifu_rd_data  <= mem_rdata;
                     ifu_rd_valid <= 1'b1;
                  end
                  OWN_EXEC_RD: begin
                     exec_rd_data  <= mem_rdata;
                     exec_rd_valid <= 1'b1;
                  end
                  default: begin
                     ifu_rd_valid  <= 1'b0;
                     exec_rd_valid <= 1'b0;
                  end
               endcase
            end
            ST_RESP: begin
               mem_en <= 1'b0;
            end
            default: begin
               mem_en <= 1'b0;
               mem_we <= 1'b0;
            end
         endcase
      end
   end

`ifdef PDP8_MEM_ARB_STATS_EN
   logic [1:0] req_cnt_s;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : (v + 16'd1);
   endfunction

   assign req_cnt_s = {1'b0, ifu_rd_req} + {1'b0, exec_rd_req} + {1'b0, exec_wr_req};

   // Saturating grant and contention statistics, updated on IDLE grant edges
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ifu_grant_cnt  <= 16'd0;
         exec_grant_cnt <= 16'd0;
         conflict_cnt   <= 16'd0;
      end else if ((state_r == ST_IDLE) && (grant_s != OWN_NONE)) begin
         if (grant_s == OWN_IFU) begin
            ifu_grant_cnt <= sat_inc16(ifu_grant_cnt);
         end else begin
            exec_grant_cnt <= sat_inc16(exec_grant_cnt);
         end
         if (req_cnt_s >= 2'd2) begin
            conflict_cnt <= sat_inc16(conflict_cnt);
         end
      end
   end
`endif

endmodule

// File: tb/tb_pdp8_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pdp8_mem_arbiter
//
// Bench for pdp8_mem_arbiter. Provides a behavioural 4096 x 12 synchronous
// memory, a transaction-level model of the arbiter (grant decision plus fixed
// read/write latencies) compared on every falling edge, and directed scenarios
// with hand-derived literal expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pdp8_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ifu_rd_req = 1'b0;
   logic [11:0] ifu_rd_addr = 12'd0;
   logic [11:0] ifu_rd_data;
   logic        ifu_rd_valid;
   logic        exec_rd_req = 1'b0;
   logic [11:0] exec_rd_addr = 12'd0;
   logic [11:0] exec_rd_data;
   logic        exec_rd_valid;
   logic        exec_wr_req = 1'b0;
   logic [11:0] exec_wr_addr = 12'd0;
   logic [11:0] exec_wr_data = 12'd0;
   logic        exec_wr_done;
   logic        mem_en;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [11:0] mem_wdata;
   logic [11:0] mem_rdata = 12'd0;
`ifdef PDP8_MEM_ARB_STATS_EN
   logic [15:0] ifu_grant_cnt;
   logic [15:0] exec_grant_cnt;
   logic [15:0] conflict_cnt;
`endif

   int vectors = 0;
   int miscompares = 0;
   bit finished = 1'b0;

   always #5 clk = ~clk;

   pdp8_mem_arbiter dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .ifu_rd_req    (ifu_rd_req),
      .ifu_rd_addr   (ifu_rd_addr),
      .ifu_rd_data   (ifu_rd_data),
      .ifu_rd_valid  (ifu_rd_valid),
      .exec_rd_req   (exec_rd_req),
      .exec_rd_addr  (exec_rd_addr),
      .exec_rd_data  (exec_rd_data),
      .exec_rd_valid (exec_rd_valid),
      .exec_wr_req   (exec_wr_req),
      .exec_wr_addr  (exec_wr_addr),
      .exec_wr_data  (exec_wr_data),
      .exec_wr_done  (exec_wr_done),
      .mem_en        (mem_en),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata)
`ifdef PDP8_MEM_ARB_STATS_EN
      ,
      .ifu_grant_cnt (ifu_grant_cnt),
      .exec_grant_cnt(exec_grant_cnt),
      .conflict_cnt  (conflict_cnt)
`endif
   );

   function automatic logic [11:0] init_val(input int i);
      if (i == 'o200) return 12'o1234;
      return 12'(i * 5 + 1);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Synchronous single-port memory, preloaded on its first clock
   logic [11:0] mem [0:4095];
   bit mem_loaded = 1'b0;
   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);
         mem_loaded <= 1'b1;
      end else if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem[mem_addr];
      end
   end

   // ---------------- transaction-level reference model ----------------
   logic [11:0] ref_mem [0:4095];
   int          m_since;      // edges since grant, -1 when waiting for a request
   int          m_owner;      // 0 ifu, 1 exec read, 2 exec write
   int          m_starve;
   logic        m_en, m_we, m_ifu_v, m_exec_v, m_done;
   logic [11:0] m_addr, m_wdata, m_ifu_data, m_exec_data, m_pend;
   logic [15:0] m_ifu_cnt, m_exec_cnt, m_conf;

   task automatic model_reset();
      m_since = -1; m_owner = 0; m_starve = 0;
      m_en = 1'b0; m_we = 1'b0; m_ifu_v = 1'b0; m_exec_v = 1'b0; m_done = 1'b0;
      m_addr = 12'd0; m_wdata = 12'd0; m_ifu_data = 12'd0; m_exec_data = 12'd0; m_pend = 12'd0;
      m_ifu_cnt = 16'd0; m_exec_cnt = 16'd0; m_conf = 16'd0;
   endtask

   task automatic model_step();
      int w;
      int nreq;
      m_ifu_v = 1'b0; m_exec_v = 1'b0; m_done = 1'b0;
      if (m_since < 0) begin
         nreq = int'(ifu_rd_req) + int'(exec_rd_req) + int'(exec_wr_req);
         w = -1;
         if (ifu_rd_req && (m_starve >= 4 || (!exec_wr_req && !exec_rd_req))) w = 0;
         else if (exec_wr_req) w = 2;
         else if (exec_rd_req) w = 1;
         if (ifu_rd_req && w != 0) m_starve = (m_starve < 4) ? m_starve + 1 : 4;
         else m_starve = 0;
         if (w >= 0) begin
            m_since = 0; m_owner = w; m_en = 1'b1; m_we = (w == 2);
            if (w == 0) m_addr = ifu_rd_addr;
            else if (w == 1) m_addr = exec_rd_addr;
            else begin
               m_addr = exec_wr_addr; m_wdata = exec_wr_data;
               ref_mem[m_addr] = m_wdata;
            end
            if (w != 2) m_pend = ref_mem[m_addr];
            if (w == 0) m_ifu_cnt = (m_ifu_cnt == 16'hFFFF) ? m_ifu_cnt : m_ifu_cnt + 16'd1;
            else m_exec_cnt = (m_exec_cnt == 16'hFFFF) ? m_exec_cnt : m_exec_cnt + 16'd1;
            if (nreq >= 2) m_conf = (m_conf == 16'hFFFF) ? m_conf : m_conf + 16'd1;
         end
      end else begin
         m_since++;
         if (m_since == 1) begin
            m_en = 1'b0; m_we = 1'b0;
            if (m_owner == 2) m_done = 1'b1;
         end else if (m_since == 2 && m_owner == 2) begin
            m_since = -1;
         end else if (m_since == 2) begin
            if (m_owner == 0) begin m_ifu_v = 1'b1; m_ifu_data = m_pend; end
            else begin m_exec_v = 1'b1; m_exec_data = m_pend; end
         end else begin
            m_since = -1;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
      model_reset();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) model_reset();
         else model_step();
      end
   end

   // Cycle-by-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         if (!finished) begin
            chk("mem_en", 32'(mem_en), 32'(m_en));
            chk("mem_we", 32'(mem_we), 32'(m_we));
            chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            if (m_we) chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            chk("ifu_rd_valid", 32'(ifu_rd_valid), 32'(m_ifu_v));
            chk("ifu_rd_data", 32'(ifu_rd_data), 32'(m_ifu_data));
            chk("exec_rd_valid", 32'(exec_rd_valid), 32'(m_exec_v));
            chk("exec_rd_data", 32'(exec_rd_data), 32'(m_exec_data));
            chk("exec_wr_done", 32'(exec_wr_done), 32'(m_done));
`ifdef PDP8_MEM_ARB_STATS_EN
            chk("ifu_grant_cnt", 32'(ifu_grant_cnt), 32'(m_ifu_cnt));
            chk("exec_grant_cnt", 32'(exec_grant_cnt), 32'(m_exec_cnt));
            chk("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d vectors so far", vectors);
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed stimulus ----------------
   // Starts on a falling edge in IDLE; returns edges until valid and mem_en cycles.
   task automatic fetch(input logic [11:0] a, input bit hold, output logic [11:0] d,
                        output int cyc, output int en);
      ifu_rd_addr = a; ifu_rd_req = 1'b1; cyc = 0; en = 0; d = 12'd0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (mem_en) en++;
         if (ifu_rd_valid) begin cyc = i; d = ifu_rd_data; break; end
      end
      chk("fetch_completes", 32'(cyc != 0), 32'd1);
      // Holding past the next IDLE edge makes it a new request
      if (hold) repeat (2) @(negedge clk);
      ifu_rd_req = 1'b0;
      if (!hold) @(negedge clk);
   endtask

   task automatic wr_fetch(input logic [11:0] wa, input logic [11:0] wd, input logic [11:0] fa,
                           output int wr_at, output int if_at, output logic [11:0] d);
      exec_wr_addr = wa; exec_wr_data = wd; exec_wr_req = 1'b1;
      ifu_rd_addr = fa; ifu_rd_req = 1'b1;
      wr_at = 0; if_at = 0; d = 12'd0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (exec_wr_done) begin wr_at = i; exec_wr_req = 1'b0; end
         if (ifu_rd_valid) begin if_at = i; d = ifu_rd_data; ifu_rd_req = 1'b0; break; end
      end
      exec_wr_req = 1'b0; ifu_rd_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_write(input logic [11:0] a, input logic [11:0] d, output int at);
      exec_wr_addr = a; exec_wr_data = d; exec_wr_req = 1'b1; at = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (exec_wr_done) begin at = i; break; end
      end
      exec_wr_req = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [11:0] d;
      int cyc, en, wr_at, if_at, n_exec, n_valid;

      repeat (3) @(negedge clk);
      chk("reset_mem_en", 32'(mem_en), 32'd0);
      chk("reset_ifu_valid", 32'(ifu_rd_valid), 32'd0);
      chk("reset_mem_addr", 32'(mem_addr), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // 1: plain fetch, three-cycle latency, one mem_en cycle
      fetch(12'o200, 1'b0, d, cyc, en);
      chk("t1_data", 32'(d), 32'o1234);
      chk("t1_latency", 32'(cyc), 32'd3);
      chk("t1_mem_en_cycles", 32'(en), 32'd1);

      // 2: contended write then fetch of the same address sees the new word
      wr_fetch(12'o300, 12'o7777, 12'o300, wr_at, if_at, d);
      chk("t2_wr_done_at", 32'(wr_at), 32'd2);
      chk("t2_fetch_at", 32'(if_at), 32'd6);
      chk("t2_data", 32'(d), 32'o7777);

      // 3: starvation guard lets IFD in after four lost IDLE cycles
      exec_rd_addr = 12'o10; exec_rd_req = 1'b1;
      ifu_rd_addr = 12'o20; ifu_rd_req = 1'b1;
      n_exec = 0; d = 12'd0; cyc = 0;
      for (int i = 1; i <= 80; i++) begin
         @(negedge clk);
         if (exec_rd_valid) begin n_exec++; exec_rd_addr = exec_rd_addr + 12'd1; end
         if (ifu_rd_valid) begin cyc = i; d = ifu_rd_data; break; end
      end
      ifu_rd_req = 1'b0; exec_rd_req = 1'b0;
      @(negedge clk);
      chk("t3_exec_wins", 32'(n_exec), 32'd4);
      chk("t3_ifu_done", 32'(cyc != 0), 32'd1);
      chk("t3_data", 32'(d), 32'(init_val('o20)));

      // 4: reset during DATA of an exec read drops it
      exec_rd_addr = 12'o30; exec_rd_req = 1'b1;
      repeat (2) @(negedge clk);
      #1 reset_n = 1'b0;
      #1;
      chk("t4_mem_en", 32'(mem_en), 32'd0);
      chk("t4_mem_we", 32'(mem_we), 32'd0);
      chk("t4_mem_addr", 32'(mem_addr), 32'd0);
      chk("t4_exec_valid", 32'(exec_rd_valid), 32'd0);
      chk("t4_ifu_data", 32'(ifu_rd_data), 32'd0);
      exec_rd_req = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      n_valid = 0;
      repeat (4) begin
         @(negedge clk);
         if (exec_rd_valid) n_valid++;
      end
      chk("t4_no_exec_valid", 32'(n_valid), 32'd0);
      fetch(12'o200, 1'b0, d, cyc, en);
      chk("t4_fetch_latency", 32'(cyc), 32'd3);
      chk("t4_fetch_data", 32'(d), 32'o1234);

      // 5: request held one cycle too long yields a second fetch
      fetch(12'o40, 1'b1, d, cyc, en);
      chk("t5_first_data", 32'(d), 32'(init_val('o40)));
      n_valid = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (ifu_rd_valid) begin n_valid++; d = ifu_rd_data; break; end
      end
      @(negedge clk);
      chk("t5_second_pulse", 32'(n_valid), 32'd1);
      chk("t5_second_data", 32'(d), 32'(init_val('o40)));

      // Uncontended write followed by read-back
      do_write(12'o600, 12'o4321, wr_at);
      chk("wr_done_at", 32'(wr_at), 32'd2);
      fetch(12'o600, 1'b0, d, cyc, en);
      chk("wr_readback", 32'(d), 32'o4321);

`ifdef PDP8_MEM_ARB_STATS_EN
      // 6: statistics after 3 fetches and 2 writes, one contended
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      wr_fetch(12'o400, 12'o0123, 12'o500, wr_at, if_at, d);
      fetch(12'o200, 1'b0, d, cyc, en);
      fetch(12'o400, 1'b0, d, cyc, en);
      chk("t6_readback", 32'(d), 32'o0123);
      do_write(12'o410, 12'o0055, wr_at);
      chk("t6_ifu_grants", 32'(ifu_grant_cnt), 32'd3);
      chk("t6_exec_grants", 32'(exec_grant_cnt), 32'd2);
      chk("t6_conflicts", 32'(conflict_cnt), 32'd1);
`endif

      repeat (2) @(negedge clk);
      finished = 1'b1;
      @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
